// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a gate-level WIDTH-bit bitwise logic unit.
// One transaction at a time: IDLE (grant) -> EXEC (compute) -> RESP (hold until taken).

module logic_unit_gates #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] not_s;
    logic [WIDTH-1:0] and_s;
    logic [WIDTH-1:0] or_s;
    logic [WIDTH-1:0] xor_s;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i = i + 1) begin : g_bit
            not u_not (not_s[i], a[i]);
            and u_and (and_s[i], a[i], b[i]);
            or  u_or  (or_s[i],  a[i], b[i]);
            xor u_xor (xor_s[i], a[i], b[i]);
        end
    endgenerate

    // Op code picks one of the four gate arrays
    always_comb begin
        y = {WIDTH{1'b0}};
        case (op)
            2'b00:   y = not_s;
            2'b01:   y = and_s;
            2'b10:   y = or_s;
            2'b11:   y = xor_s;
            default: y = {WIDTH{1'b0}};
        endcase
    end
endmodule

module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t           state_r;
    logic             last_grant_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             id_r;

    logic             grant_valid_s;
    logic             grant_id_s;
    logic [1:0]       sel_op_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [WIDTH-1:0] lu_result_s;

    // Round-robin pick: on contention the requester that did not win last time goes
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = ~last_grant_r;
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Ready is only offered in IDLE and is forced low while reset is asserted
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && (state_r == S_IDLE) && grant_valid_s) begin
            req0_ready = ~grant_id_s;
            req1_ready = grant_id_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Operand mux feeding the capture registers
    always_comb begin
        sel_op_s = req0_op;
        sel_a_s  = req0_a;
        sel_b_s  = req0_b;
        if (grant_id_s) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    logic_unit_gates #(
        .WIDTH (WIDTH)
    ) u_lu (
        .op (op_r),
        .a  (a_r),
        .b  (b_r),
        .y  (lu_result_s)
    );

    // Transaction sequencer; response fields keep their value after rsp_valid drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            last_grant_r <= 1'b1;
            op_r         <= 2'b00;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            id_r         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_data     <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (grant_valid_s) begin
                        op_r         <= sel_op_s;
                        a_r          <= sel_a_s;
                        b_r          <= sel_b_s;
                        id_r         <= grant_id_s;
                        last_grant_r <= grant_id_s;
                        state_r      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data  <= lu_result_s;
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state_r   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end
endmodule
